// File: rtl/lc3_io_pkg.sv
// -----------------------------------------------------------------------------
// lc3_io_pkg
// Shared definitions for the LC-3 bus-side memory/I/O interface:
//   - memory-mapped device register addresses (KBSR, KBDR, DSR, DDR)
//   - access FSM state encoding
//   - default memory latency
//   - address decode helper for the device window
// -----------------------------------------------------------------------------
package lc3_io_pkg;

  localparam int MEM_LATENCY_DEF = 2;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Only the four device registers are decoded; the rest of xFExx is memory.
  function automatic logic is_dev_addr(input logic [15:0] addr);
    return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) ||
           (addr == ADDR_DSR)  || (addr == ADDR_DDR);
  endfunction

endpackage

// File: rtl/mem_io_unit_mmio_regs.sv
// -----------------------------------------------------------------------------
// mmio_regs
// Keyboard and display device registers with address decode and read mux.
// Ports:
//   Clk, Reset    : system clock, asynchronous active-high reset
//   i_req         : access starts this cycle (FSM in IDLE with MIO_EN high)
//   i_addr        : access address (current MAR)
//   i_write       : access direction, 1 = write
//   i_wdata       : access write data (current MDR)
//   kbd_strobe    : new keyboard character present this cycle
//   kbd_data      : keyboard character
//   dsp_busy      : display cannot accept a character
//   o_is_dev      : i_addr hits a device register
//   o_rdata       : device read value for i_addr (0 for DDR)
//   o_dsp_valid   : one-cycle display write strobe
//   o_dsp_data    : character to display
// -----------------------------------------------------------------------------
module mmio_regs
  import lc3_io_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_write,
  input  logic [15:0] i_wdata,
  input  logic        kbd_strobe,
  input  logic [7:0]  kbd_data,
  input  logic        dsp_busy,
  output logic        o_is_dev,
  output logic [15:0] o_rdata,
  output logic        o_dsp_valid,
  output logic [7:0]  o_dsp_data
);

  logic [7:0] r_kbdr;
  logic       r_kbd_ready;
  logic       r_dsp_valid;
  logic [7:0] r_dsp_data;

  logic w_start;
  logic w_kbdr_read;
  logic w_ddr_write;

  assign o_is_dev    = is_dev_addr(i_addr);
  assign w_start     = i_req & o_is_dev;
  assign w_kbdr_read = w_start & ~i_write & (i_addr == ADDR_KBDR);
  assign w_ddr_write = w_start &  i_write & (i_addr == ADDR_DDR);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch is inferred.
  always_comb begin
    o_rdata = 16'h0000;
    unique case (i_addr)
      ADDR_KBSR: o_rdata = {r_kbd_ready, 15'b0};
      ADDR_KBDR: o_rdata = {8'b0, r_kbdr};
      ADDR_DSR:  o_rdata = {~dsp_busy, 15'b0};
      default:   o_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_kbdr      <= 8'h00;
      r_kbd_ready <= 1'b0;
      r_dsp_valid <= 1'b0;
      r_dsp_data  <= 8'h00;
    end else begin
      r_dsp_valid <= w_ddr_write;
      if (w_ddr_write) r_dsp_data <= i_wdata[7:0];
      // A strobe in the same cycle as a KBDR read keeps the ready flag set,
      // since the read returned the previous character.
      if (kbd_strobe) begin
        r_kbdr      <= kbd_data;
        r_kbd_ready <= 1'b1;
      end else if (w_kbdr_read) begin
        r_kbd_ready <= 1'b0;
      end
    end
  end

  assign o_dsp_valid = r_dsp_valid;
  assign o_dsp_data  = r_dsp_data;

endmodule

// File: rtl/mem_io_unit.sv
// -----------------------------------------------------------------------------
// mem_io_unit
// Bus-side memory and I/O interface for the LC-3 datapath. Latches BUS into
// MAR/MDR, runs memory-mapped reads/writes and signals completion on R.
// Ports:
//   Clk, Reset          : system clock, asynchronous active-high reset
//   BUS                 : datapath bus value
//   LD_MAR, LD_MDR      : load MAR / MDR at next edge
//   MIO_EN, R_W         : access request and direction (1 = write)
//   MAR, MDR            : address and data registers
//   R                   : access complete, one-cycle pulse
//   mem_addr/wdata/rdata, mem_ce, mem_we : memory port
//   kbd_strobe, kbd_data: keyboard input
//   dsp_busy, dsp_valid, dsp_data : display output
// -----------------------------------------------------------------------------
module mem_io_unit
  import lc3_io_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] BUS,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        MIO_EN,
  input  logic        R_W,
  output logic [15:0] MAR,
  output logic [15:0] MDR,
  output logic        R,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_ce,
  output logic        mem_we,
  input  logic        kbd_strobe,
  input  logic [7:0]  kbd_data,
  input  logic        dsp_busy,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_mar;
  logic [15:0]      r_mdr;
  logic [15:0]      r_addr;
  logic             r_we;
  logic [15:0]      r_wdata;
  logic [15:0]      r_rdata;
  logic             r_r;
  logic             r_mem_ce;
  logic             r_mem_we;

  logic             w_req;
  logic             w_is_dev;
  logic [15:0]      w_dev_rdata;

  assign w_req = (r_state == IDLE) & MIO_EN;

  mmio_regs u_mmio_regs (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_req       (w_req),
    .i_addr      (r_mar),
    .i_write     (R_W),
    .i_wdata     (r_mdr),
    .kbd_strobe  (kbd_strobe),
    .kbd_data    (kbd_data),
    .dsp_busy    (dsp_busy),
    .o_is_dev    (w_is_dev),
    .o_rdata     (w_dev_rdata),
    .o_dsp_valid (dsp_valid),
    .o_dsp_data  (dsp_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mar <= 16'h0000;
      r_mdr <= 16'h0000;
    end else begin
      if (LD_MAR) r_mar <= BUS;
      // Read data is handed to MDR only in the completion cycle of a read.
      if (LD_MDR && !MIO_EN)                   r_mdr <= BUS;
      else if (LD_MDR && MIO_EN && r_r && !r_we) r_mdr <= r_rdata;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= 16'h0000;
      r_we     <= 1'b0;
      r_wdata  <= 16'h0000;
      r_rdata  <= 16'h0000;
      r_r      <= 1'b0;
      r_mem_ce <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (MIO_EN) begin
            r_addr  <= r_mar;
            r_we    <= R_W;
            r_wdata <= r_mdr;
            r_cnt   <= '0;
            if (w_is_dev) begin
              // Device accesses complete in one cycle; read value captured now.
              r_state <= DONE;
              r_r     <= 1'b1;
              if (!R_W) r_rdata <= w_dev_rdata;
            end else begin
              r_state  <= ACCESS;
              r_mem_ce <= 1'b1;
              r_mem_we <= R_W;
            end
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            r_state  <= DONE;
            r_mem_ce <= 1'b0;
            r_mem_we <= 1'b0;
            r_r      <= 1'b1;
            if (!r_we) r_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_r     <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MAR       = r_mar;
  assign MDR       = r_mdr;
  assign R         = r_r;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_ce    = r_mem_ce;
  assign mem_we    = r_mem_we;

endmodule
